// File: rtl/gate_tt_pkg.sv
// gate_tt_pkg: shared FSM state encodings and reference truth tables for gate_tt_checker.
//   Contents: state_e (ST_IDLE/ST_SETTLE/ST_SAMPLE/ST_DONE), TT_NOR/TT_AND/TT_OR/TT_NAND.
package gate_tt_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
endpackage

// File: rtl/gate_tt_checker_if.sv
// gate_tt_checker_if: pattern/response link between the checker and a combinational gate DUT.
//   dut_in  [N_IN] : pattern driven by the checker (master), bit N_IN-1 is the leftmost input
//   dut_out [1]    : combinational DUT response (driven by slave side)
interface gate_tt_checker_if #(parameter int N_IN = 2);
    logic [N_IN-1:0] dut_in;
    logic            dut_out;
    modport master (output dut_in, input dut_out);
    modport slave  (input dut_in, output dut_out);
endinterface

// File: rtl/gate_tt_settle_cnt.sv
// gate_tt_settle_cnt: loadable down-counter with zero flag, paces the settle time per pattern.
//   clk, reset : clock, synchronous active-high reset
//   load/load_val : load counter (priority over dec)
//   dec        : decrement when nonzero
//   zero       : counter value is zero
module gate_tt_settle_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else if (load) cnt_q <= load_val;
        else if (dec && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
    assign zero = cnt_q == '0;
endmodule

// File: rtl/gate_tt_checker.sv
// gate_tt_checker: sweeps all input patterns into a combinational gate and scores it against EXP_TT.
//   clk, reset  : clock, synchronous active-high reset
//   start       : begin a sweep (accepted in idle/done only)
//   gif         : master side of gate_tt_checker_if (dut_in out, dut_out in)
//   busy, done, pass, err_count, obs_tt : sweep status and captured results
//   Optional macro GATE_TT_STOP_ON_ERR_EN: end the sweep at the first mismatch.
module gate_tt_checker
    import gate_tt_pkg::*;
#(
    parameter int                   N_IN   = 2,
    parameter logic [(1<<N_IN)-1:0] EXP_TT = 4'b0001,
    parameter int                   SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    gate_tt_checker_if.master      gif,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          err_count,
    output logic [(1<<N_IN)-1:0]   obs_tt
);
    localparam int TW = 1 << N_IN;
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    if (SETTLE < 1) $error("gate_tt_checker: SETTLE must be >= 1");
    if (N_IN < 1 || N_IN > 4) $error("gate_tt_checker: N_IN must be 1..4");
    state_e          state_q;
    logic [N_IN-1:0] idx_q;
    logic [N_IN-1:0] dut_in_q;
    logic            busy_q, done_q, pass_q;
    logic [N_IN:0]   err_q, err_d;
    logic [TW-1:0]   obs_q;
    logic            mis, fin, go, cnt_load, cnt_zero;
    always_comb begin
        mis      = gif.dut_out != EXP_TT[idx_q];
        err_d    = err_q + (N_IN+1)'(mis);
`ifdef GATE_TT_STOP_ON_ERR_EN
        fin      = idx_q == '1 || mis;
`else
        fin      = idx_q == '1;
`endif
        go       = start && (state_q == ST_IDLE || state_q == ST_DONE);
        cnt_load = go || (state_q == ST_SAMPLE && !fin);
    end
    gate_tt_settle_cnt #(.W(CW)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (state_q == ST_SETTLE),
        .load_val (CW'(SETTLE - 1)),
        .zero     (cnt_zero)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            dut_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            obs_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (go) begin
                    state_q  <= ST_SETTLE;
                    idx_q    <= '0;
                    dut_in_q <= '0;
                    busy_q   <= 1'b1;
                    done_q   <= 1'b0;
                    pass_q   <= 1'b0;
                    err_q    <= '0;
                    obs_q    <= '0;
                end
                ST_SETTLE: if (cnt_zero) state_q <= ST_SAMPLE;
                default: begin
                    obs_q[idx_q] <= gif.dut_out;
                    err_q        <= err_d;
                    if (fin) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= err_d == '0;
                    end else begin
                        state_q  <= ST_SETTLE;
                        idx_q    <= idx_q + 1'b1;
                        dut_in_q <= idx_q + 1'b1;
                    end
                end
            endcase
        end
    end
    assign gif.dut_in = dut_in_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign obs_tt     = obs_q;
endmodule

// File: tb/tb_gate_tt_checker.sv
// tb_gate_tt_checker: directed checks of gate_tt_checker with NOR/AND/stuck-at-1 gate models.
module tb_gate_tt_checker;
    import gate_tt_pkg::*;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       start3 = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       busy, done, pass, busy3, done3, pass3;
    logic [2:0] err_count, err3;
    logic [3:0] obs_tt, obs3;
    int         checks = 0;
    int         errors = 0;
    always #5 clk = ~clk;
    gate_tt_checker_if #(.N_IN(2)) gif0 ();
    gate_tt_checker_if #(.N_IN(2)) gif3 ();
    assign gif0.dut_out = mode == 2'd0 ? ~|gif0.dut_in : mode == 2'd1 ? &gif0.dut_in : 1'b1;
    assign gif3.dut_out = ~|gif3.dut_in;
    gate_tt_checker #(.N_IN(2), .EXP_TT(TT_NOR), .SETTLE(1)) u0 (
        .clk(clk), .reset(reset), .start(start), .gif(gif0),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .obs_tt(obs_tt)
    );
    gate_tt_checker #(.N_IN(2), .EXP_TT(TT_NOR), .SETTLE(3)) u3 (
        .clk(clk), .reset(reset), .start(start3), .gif(gif3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .obs_tt(obs3)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic pulse_start;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".pass"}, pass, 0);
        chk({tag, ".err"}, err_count, 0);
        chk({tag, ".obs"}, obs_tt, 0);
        chk({tag, ".din"}, gif0.dut_in, 0);
    endtask
    initial begin
        tick(2);
        chk_zero("rst");
        chk("rst.busy3", busy3, 0);
        reset = 1'b0;
        tick(1);
        chk_zero("idle");
        // NOR sweep: dut_in steps 0..3, two edges each, done on 9th edge
        mode = 2'd0;
        pulse_start();
        chk("nor.busy", busy, 1);
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) tick(1);
            chk($sformatf("nor.din%0d", k), gif0.dut_in, k < 9 ? (k - 1) / 2 : 3);
            chk($sformatf("nor.done%0d", k), done, k == 9);
        end
        chk("nor.pass", pass, 1);
        chk("nor.err", err_count, 0);
        chk("nor.obs", obs_tt, 4'b0001);
        chk("nor.busy_end", busy, 0);
        // AND gate against NOR table, restart from DONE clears results
        mode = 2'd1;
        pulse_start();
        chk("and.rst_done", done, 0);
        chk("and.rst_err", err_count, 0);
        chk("and.rst_obs", obs_tt, 0);
        tick(8);
        chk("and.done", done, 1);
        chk("and.obs", obs_tt, 4'b1000);
        chk("and.err", err_count, 2);
        chk("and.pass", pass, 0);
        // stuck-at-1 gate
        mode = 2'd2;
        pulse_start();
`ifdef GATE_TT_STOP_ON_ERR_EN
        tick(3);
        chk("s1.done4", done, 0);
        tick(1);
        chk("s1.done", done, 1);
        chk("s1.err", err_count, 1);
        chk("s1.obs", obs_tt, 4'b0011);
`else
        tick(7);
        chk("s1.done8", done, 0);
        tick(1);
        chk("s1.done", done, 1);
        chk("s1.err", err_count, 3);
        chk("s1.obs", obs_tt, 4'b1111);
`endif
        chk("s1.pass", pass, 0);
        // reset mid-sweep, then a clean sweep
        mode = 2'd0;
        pulse_start();
        tick(3);
        chk("mid.busy", busy, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk_zero("mid");
        pulse_start();
        tick(8);
        chk("mid.done", done, 1);
        chk("mid.pass", pass, 1);
        // start held high: ignored while busy, restarts once in DONE
        start = 1'b1;
        tick(9);
        chk("hold.done", done, 1);
        chk("hold.pass", pass, 1);
        chk("hold.obs", obs_tt, 4'b0001);
        tick(1);
        chk("hold.re_done", done, 0);
        chk("hold.re_busy", busy, 1);
        chk("hold.re_obs", obs_tt, 0);
        start = 1'b0;
        tick(7);
        chk("hold.done8", done, 0);
        tick(1);
        chk("hold.done2", done, 1);
        chk("hold.pass2", pass, 1);
        // SETTLE=3: each pattern held 4 cycles, done on 17th edge
        start3 = 1'b1;
        tick(1);
        start3 = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            if (k > 1) tick(1);
            chk($sformatf("s3.din%0d", k), gif3.dut_in, k < 17 ? (k - 1) / 4 : 3);
            chk($sformatf("s3.done%0d", k), done3, k == 17);
        end
        chk("s3.pass", pass3, 1);
        chk("s3.err", err3, 0);
        chk("s3.obs", obs3, 4'b0001);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
